// File: rtl/knn_pkg.sv
// Shared constants, state encoding and helpers for the kNN image loader.
package knn_pkg;

    localparam int IMAGE_SIZE = 784;
    localparam int ADDR_W     = 10;
    localparam int NUM_CLASS  = 10;

    localparam logic [3:0]        LABEL_ERR = 4'hF;
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(IMAGE_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        START,
        RUN,
        REPORT
    } loader_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/knn_pixel_ram.sv
// Image buffer: one write port, one registered read port; out-of-range reads return 0.
import knn_pkg::*;

module knn_pixel_ram #(
    parameter int DEPTH = IMAGE_SIZE,
    parameter int AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_q;
    logic [7:0] rd_data_d;

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = (rd_addr < AW'(DEPTH)) ? mem[rd_addr] : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/knn_image_loader.sv
// Buffers one 28x28 pixel frame, launches the kNN core and returns its label to the host.
// Define KNN_LOADER_PERF_CNT_EN to report core cycles per image on res_cycles.
//
// state  | meaning
// IDLE   | wait for core idle before accepting a frame
// LOAD   | accept pixels into the buffer
// DRAIN  | frame too long, discard beats until tlast
// START  | hold ap_start until the core acknowledges with ap_ready
// RUN    | core reads the buffer, wait for result_ap_vld
// REPORT | present result to host until res_ready
import knn_pkg::*;

module knn_image_loader (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [7:0]        s_pix_tdata,
    input  logic              s_pix_tvalid,
    input  logic              s_pix_tlast,
    output logic              s_pix_tready,
    output logic              knn_ap_start,
    input  logic              knn_ap_ready,
    input  logic              knn_ap_idle,
    input  logic [ADDR_W-1:0] knn_addr,
    input  logic              knn_ce,
    output logic [7:0]        knn_q,
    input  logic [31:0]       knn_result,
    input  logic              knn_result_vld,
    output logic [3:0]        res_label,
    output logic              res_err,
    output logic [31:0]       res_cycles,
    output logic              res_valid,
    input  logic              res_ready
);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              tready_q, tready_d;
    logic              start_q, start_d;
    logic [3:0]        label_q, label_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;

    logic beat;
    logic wr_en;
    logic rd_en;

    assign beat  = s_pix_tvalid & tready_q;
    assign wr_en = beat & (state_q == LOAD);
    // Core reads only honoured while it owns the buffer, so RAM ports never collide.
    assign rd_en = knn_ce & ((state_q == START) | (state_q == RUN));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tready_d = tready_q;
        start_d  = start_q;
        label_d  = label_q;
        err_d    = err_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (knn_ap_idle) begin
                    state_d  = LOAD;
                    tready_d = 1'b1;
                end
            end
            LOAD: begin
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (s_pix_tlast) begin
                        tready_d = 1'b0;
                        if (cnt_q == LAST_PIX) begin
                            state_d = START;
                            start_d = 1'b1;
                        end else begin
                            state_d = REPORT;
                            valid_d = 1'b1;
                            label_d = LABEL_ERR;
                            err_d   = 1'b1;
                        end
                    end else if (cnt_q == LAST_PIX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (beat && s_pix_tlast) begin
                    state_d  = REPORT;
                    tready_d = 1'b0;
                    valid_d  = 1'b1;
                    label_d  = LABEL_ERR;
                    err_d    = 1'b1;
                end
            end
            START: begin
                if (knn_ap_ready) begin
                    state_d = RUN;
                    start_d = 1'b0;
                end
            end
            RUN: begin
                if (knn_result_vld) begin
                    state_d = REPORT;
                    valid_d = 1'b1;
                    label_d = knn_result[3:0];
                    err_d   = (knn_result >= 32'(NUM_CLASS));
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    label_d = 4'h0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                tready_d = 1'b0;
                start_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tready_q <= 1'b0;
            start_q  <= 1'b0;
            label_q  <= 4'h0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tready_q <= tready_d;
            start_q  <= start_d;
            label_q  <= label_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

`ifdef KNN_LOADER_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;
    logic [31:0] cycles_q, cycles_d;

    // Count includes the cycle on which the result is captured.
    always_comb begin
        perf_d   = perf_q;
        cycles_d = cycles_q;
        if (state_d == START && state_q != START) begin
            perf_d = '0;
        end else if (state_q == START || state_q == RUN) begin
            perf_d = sat_inc(perf_q);
        end
        if (state_d == REPORT && state_q != REPORT) begin
            cycles_d = (state_q == RUN) ? sat_inc(perf_q) : '0;
        end else if (state_q == REPORT && res_ready) begin
            cycles_d = '0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            perf_q   <= '0;
            cycles_q <= '0;
        end else begin
            perf_q   <= perf_d;
            cycles_q <= cycles_d;
        end
    end

    assign res_cycles = cycles_q;
`else
    assign res_cycles = 32'd0;
`endif

    knn_pixel_ram #(
        .DEPTH (IMAGE_SIZE),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .wr_en   (wr_en),
        .wr_addr (cnt_q),
        .wr_data (s_pix_tdata),
        .rd_en   (rd_en),
        .rd_addr (knn_addr),
        .rd_data (knn_q)
    );

    assign s_pix_tready = tready_q;
    assign knn_ap_start = start_q;
    assign res_label    = label_q;
    assign res_err      = err_q;
    assign res_valid    = valid_q;

endmodule

// File: tb/tb_knn_image_loader.sv
// Self-checking bench for knn_image_loader with a behavioural core stub and frame-level model.
import knn_pkg::*;

module tb_knn_image_loader;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic [7:0]        s_pix_tdata = '0;
    logic              s_pix_tvalid = 1'b0;
    logic              s_pix_tlast = 1'b0;
    logic              s_pix_tready;
    logic              knn_ap_start;
    logic              knn_ap_ready = 1'b0;
    logic              knn_ap_idle = 1'b0;
    logic [ADDR_W-1:0] knn_addr = '0;
    logic              knn_ce = 1'b0;
    logic [7:0]        knn_q;
    logic [31:0]       knn_result = '0;
    logic              knn_result_vld = 1'b0;
    logic [3:0]        res_label;
    logic              res_err;
    logic [31:0]       res_cycles;
    logic              res_valid;
    logic              res_ready = 1'b0;

    knn_image_loader dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .s_pix_tdata    (s_pix_tdata),
        .s_pix_tvalid   (s_pix_tvalid),
        .s_pix_tlast    (s_pix_tlast),
        .s_pix_tready   (s_pix_tready),
        .knn_ap_start   (knn_ap_start),
        .knn_ap_ready   (knn_ap_ready),
        .knn_ap_idle    (knn_ap_idle),
        .knn_addr       (knn_addr),
        .knn_ce         (knn_ce),
        .knn_q          (knn_q),
        .knn_result     (knn_result),
        .knn_result_vld (knn_result_vld),
        .res_label      (res_label),
        .res_err        (res_err),
        .res_cycles     (res_cycles),
        .res_valid      (res_valid),
        .res_ready      (res_ready)
    );

    always #5 ap_clk = ~ap_clk;

    int         total = 0;
    int         bad = 0;
    int         start_rises = 0;
    logic       start_prev = 1'b0;
    logic [7:0] img [IMAGE_SIZE];
    logic [7:0] last_q = 8'h00;

    typedef struct {
        int          len;
        logic [31:0] result;
        logic [3:0]  lab;
        bit          err;
        bit          start;
    } vec_t;

    vec_t tbl [11];

    always @(negedge ap_clk) begin
        if (knn_ap_start && !start_prev) start_rises++;
        start_prev = knn_ap_start;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Frame-level rule: only an exact-length frame reaches the core.
    task automatic model(input int len, input logic [31:0] result,
                         output logic [3:0] lab, output bit err, output bit starts);
        if (len == IMAGE_SIZE) begin
            lab    = 4'(result % 16);
            err    = (result >= 32'(NUM_CLASS));
            starts = 1'b1;
        end else begin
            lab    = 4'hF;
            err    = 1'b1;
            starts = 1'b0;
        end
    endtask

    task automatic send_frame(input int len, input bit gaps);
        int n;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(7) == 0) begin
                s_pix_tvalid = 1'b0;
                tick();
            end
            s_pix_tdata  = (i < IMAGE_SIZE) ? img[i] : 8'($urandom);
            s_pix_tlast  = (i == len - 1);
            s_pix_tvalid = 1'b1;
            n = 0;
            while (!s_pix_tready && n < 100) begin
                tick();
                n++;
            end
            if (!s_pix_tready) begin
                chk("tready_timeout", 32'(s_pix_tready), 32'd1);
                break;
            end
            tick();
        end
        s_pix_tvalid = 1'b0;
        s_pix_tlast  = 1'b0;
    endtask

    task automatic run_core(input logic [31:0] result, input int rdy_dly, input int vld_dly,
                            output int cyc);
        int          n;
        int          edges;
        logic [9:0]  addrs [6];
        logic [7:0]  exp;
        n = 0;
        cyc = 0;
        while (!knn_ap_start && n < 50) begin
            tick();
            n++;
        end
        chk("ap_start_rise", 32'(knn_ap_start), 32'd1);
        if (!knn_ap_start) return;
        edges = 0;
        repeat (rdy_dly) begin
            tick();
            edges++;
        end
        knn_ap_ready = 1'b1;
        tick();
        edges++;
        knn_ap_ready = 1'b0;
        chk("ap_start_fall", 32'(knn_ap_start), 32'd0);
        addrs[0] = 10'd0;
        addrs[1] = 10'd1;
        addrs[2] = 10'd783;
        addrs[3] = 10'd784;
        addrs[4] = 10'($urandom_range(1023));
        addrs[5] = 10'($urandom_range(783));
        for (int k = 0; k < 6; k++) begin
            knn_ce   = 1'b1;
            knn_addr = addrs[k];
            tick();
            edges++;
            knn_ce = 1'b0;
            exp = (int'(addrs[k]) < IMAGE_SIZE) ? img[addrs[k]] : 8'h00;
            chk($sformatf("rd_q[%0d]", addrs[k]), 32'(knn_q), 32'(exp));
            last_q = exp;
        end
        knn_addr = 10'd2;
        tick();
        edges++;
        chk("rd_hold", 32'(knn_q), 32'(last_q));
        repeat (vld_dly) begin
            tick();
            edges++;
        end
        knn_result     = result;
        knn_result_vld = 1'b1;
        tick();
        edges++;
        knn_result_vld = 1'b0;
        cyc = edges;
    endtask

    task automatic check_report(input logic [3:0] lab, input bit err, input int cyc, input int hold);
        int n;
        int unstable;
        logic [31:0] exp_cyc;
`ifdef KNN_LOADER_PERF_CNT_EN
        exp_cyc = 32'(cyc);
`else
        exp_cyc = 32'd0;
`endif
        n = 0;
        while (!res_valid && n < 50) begin
            tick();
            n++;
        end
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_label", 32'(res_label), 32'(lab));
        chk("res_err", 32'(res_err), 32'(err));
        chk("res_cycles", res_cycles, exp_cyc);
        // Traffic the loader must ignore while it holds a result.
        unstable       = 0;
        knn_ce         = 1'b1;
        knn_addr       = 10'd5;
        s_pix_tvalid   = 1'b1;
        knn_result     = 32'd3;
        knn_result_vld = 1'b1;
        repeat (hold) begin
            tick();
            if (res_valid !== 1'b1 || res_label !== lab || res_err !== err ||
                res_cycles !== exp_cyc || s_pix_tready !== 1'b0 || knn_ap_start !== 1'b0)
                unstable++;
        end
        knn_ce         = 1'b0;
        s_pix_tvalid   = 1'b0;
        knn_result_vld = 1'b0;
        chk("report_stable", 32'(unstable), 32'd0);
        chk("rd_ignored", 32'(knn_q), 32'(last_q));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_clear", 32'(res_valid), 32'd0);
    endtask

    task automatic do_frame(input int len, input logic [31:0] result, input logic [3:0] lab,
                            input bit err, input bit starts, input bit gaps,
                            input int rdy, input int vld, input int hold);
        int s0;
        int cyc;
        s0 = start_rises;
        send_frame(len, gaps);
        cyc = 0;
        if (starts) run_core(result, rdy, vld, cyc);
        check_report(lab, err, cyc, hold);
        chk($sformatf("start_count len=%0d", len), 32'(start_rises - s0), 32'(starts));
    endtask

    initial begin
        logic [3:0]  m_lab;
        bit          m_err;
        bit          m_start;
        int          len;
        logic [31:0] result;
        int          cyc;

        tbl[0]  = '{784, 32'd7,          4'h7, 1'b0, 1'b1};
        tbl[1]  = '{784, 32'd12,         4'hC, 1'b1, 1'b1};
        tbl[2]  = '{500, 32'd0,          4'hF, 1'b1, 1'b0};
        tbl[3]  = '{790, 32'd0,          4'hF, 1'b1, 1'b0};
        tbl[4]  = '{784, 32'd9,          4'h9, 1'b0, 1'b1};
        tbl[5]  = '{784, 32'd10,         4'hA, 1'b1, 1'b1};
        tbl[6]  = '{1,   32'd0,          4'hF, 1'b1, 1'b0};
        tbl[7]  = '{783, 32'd0,          4'hF, 1'b1, 1'b0};
        tbl[8]  = '{785, 32'd0,          4'hF, 1'b1, 1'b0};
        tbl[9]  = '{784, 32'd0,          4'h0, 1'b0, 1'b1};
        tbl[10] = '{784, 32'hFFFF_FFF3,  4'h3, 1'b1, 1'b1};

        for (int i = 0; i < IMAGE_SIZE; i++) img[i] = 8'(i % 256);

        #23;
        chk("rst_tready", 32'(s_pix_tready), 32'd0);
        chk("rst_start", 32'(knn_ap_start), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_label", 32'(res_label), 32'd0);
        chk("rst_err", 32'(res_err), 32'd0);
        chk("rst_cycles", res_cycles, 32'd0);
        chk("rst_q", 32'(knn_q), 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        tick();
        tick();
        chk("idle_waits_core", 32'(s_pix_tready), 32'd0);
        knn_ap_idle = 1'b1;
        tick();
        chk("tready_after_idle", 32'(s_pix_tready), 32'd1);

        for (int t = 0; t < 11; t++) begin
            do_frame(tbl[t].len, tbl[t].result, tbl[t].lab, tbl[t].err, tbl[t].start,
                     1'b0, 3, 4, 5);
        end

        // Asynchronous reset while the core is running.
        send_frame(IMAGE_SIZE, 1'b0);
        knn_ap_ready = 1'b1;
        tick();
        knn_ap_ready = 1'b0;
        knn_ce   = 1'b1;
        knn_addr = 10'd1;
        tick();
        knn_ce = 1'b0;
        chk("pre_rst_q", 32'(knn_q), 32'(img[1]));
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("midrun_rst_q", 32'(knn_q), 32'd0);
        chk("midrun_rst_start", 32'(knn_ap_start), 32'd0);
        chk("midrun_rst_tready", 32'(s_pix_tready), 32'd0);
        chk("midrun_rst_valid", 32'(res_valid), 32'd0);
        last_q = 8'h00;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        // 3 ready + 1 + 6 reads + 1 hold + 88 + 1 = 100 cycles start to result.
        do_frame(IMAGE_SIZE, 32'd4, 4'h4, 1'b0, 1'b1, 1'b0, 3, 88, 3);

        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < IMAGE_SIZE; i++) img[i] = 8'($urandom);
            case ($urandom_range(3))
                0:       len = $urandom_range(1, 783);
                1:       len = $urandom_range(785, 900);
                default: len = IMAGE_SIZE;
            endcase
            result = ($urandom_range(1) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
            model(len, result, m_lab, m_err, m_start);
            do_frame(len, result, m_lab, m_err, m_start, 1'b1,
                     $urandom_range(0, 5), $urandom_range(0, 10), $urandom_range(2, 6));
        end

        cyc = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
